dmem_arbiter_rv32: RTL and testbench
====================================

// Module: dmem_arbiter_rv32
// PURPOSE
// - Shares the single-port RV32I data memory between two requesters: port 0 = core load/store unit, port 1 = DMA/debug.
// - Round-robin arbitration, valid/ready request and response handshakes, alignment and range checking.
// - Drives the memory's combinational addr/write_data/write_en/funct3 interface and registers the load result.
// PARAMETERS
// - AddrWidth   14   memory byte-address width; must match the memory instance
// PORTS
// - clk          in   1        rising-edge clock
// - rst_n        in   1        synchronous reset, active-low
// - req_valid    in   2        bit i: requester i presents a request
// - req_ready    out  2        bit i: request i accepted this cycle (valid&ready = accept)
// - req_we       in   2        bit i: 1 = store, 0 = load
// - req_funct3   in   6        [3i+2:3i] funct3 of requester i (F3_* encodings)
// - req_addr     in   64       [32i+31:32i] byte address of requester i
// - req_wdata    in   64       [32i+31:32i] store data of requester i
// - resp_valid   out  2        bit i: response for requester i held valid
// - resp_ready   in   2        bit i: requester i consumes response
// - resp_data    out  32       load data (sign/zero-extended by memory); 0 for stores and errors
// - resp_err     out  1        misaligned, illegal funct3 or out-of-range access
// - mem_addr     out  AddrWidth  to memory addr
// - mem_wdata    out  32       to memory write_data
// - mem_we       out  1        to memory write_en
// - mem_funct3   out  3        to memory funct3
// - mem_rdata    in   32       from memory read_data (combinational)
// BEHAVIOUR
// - FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight.
// - IDLE: grant = sole valid requester; if both valid, requester named by prio_ptr. req_ready asserted combinationally
//   to granted bit only, in IDLE only; accepted addr/wdata/we/funct3/id latched; -> ACCESS.
// - ACCESS (1 cycle): memory driven from latched fields; mem_we = latched we & ~err for exactly this cycle;
//   resp_data <= err|we ? 0 : mem_rdata; resp_err <= err; -> RESP.
// - RESP: resp_valid[id]=1, data/err stable until resp_ready[id]; on handshake -> IDLE, prio_ptr <= ~id.
// - Latency: accept in cycle N, memory access N+1, resp_valid from N+2; min 3 cycles per transaction.
// - err: addr[31:AddrWidth]!=0 | addr>2**AddrWidth-4 for word access; H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0;
//   load funct3 011/110/111; store funct3 >=011. Errored stores never write memory.
// - Outside ACCESS: mem_we=0; mem_addr/mem_wdata/mem_funct3 hold latched values.
// - Requester holding valid during another's transaction waits; no request dropped, no starvation (max wait 1 txn).
// - Reset (any state, incl. mid-ACCESS): state=IDLE, prio_ptr=0, req_ready=0, resp_valid=0, resp_data=0,
//   resp_err=0, mem_we=0 in the reset cycle, latched fields=0; in-flight transaction discarded without response.
// CONFIGURATION
// - DMEM_ARB_PERF_EN defined: adds outputs perf_grant0, perf_grant1, perf_err (32 bits each); increment on accept
//   per port and on each errored ACCESS; saturate at 32'hFFFF_FFFF; cleared by reset.
// - Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
// - Port0 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_data 0xDEADBEEF, resp_err 0, resp_valid at N+2.
// - Port1 SB 0x21 data 0x80, port0 LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080.
// - Both valid every cycle from reset -> grants 0,1,0,1; prio_ptr alternates; each port served every other txn.
// - SW addr 0x12 -> resp_err 1, mem_we never high; LW 0x10 still returns prior data; perf_err=1 if EN.
// - resp_ready held low 5 cycles -> resp_valid/resp_data stable, req_ready stays 0 for other port.
// - rst_n low during ACCESS of a SW -> no write occurs, resp_valid 0, next grant goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter_rv32.sv
// dmem_arbiter_rv32: round-robin two-port arbiter for the RV32I data memory (optional perf counters: DMEM_ARB_PERF_EN)
module dmem_arbiter_rv32 #(
  parameter int AddrWidth = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_we,
  input  logic [5:0]           req_funct3,
  input  logic [63:0]          req_addr,
  input  logic [63:0]          req_wdata,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  output logic [2:0]           mem_funct3,
  input  logic [31:0]          mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]          perf_grant0,
  output logic [31:0]          perf_grant1,
  output logic [31:0]          perf_err
`endif
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  logic [1:0]  state_q, state_d;
  logic        prio_q, prio_d, id_q, id_d, we_q, we_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        grant, accept, err;
  // Arbitration, access legality and the combinational handshake/memory outputs; reset masks them in its own cycle
  always_comb begin
    grant      = (&req_valid) ? prio_q : req_valid[1];
    accept     = rst_n && state_q == S_IDLE && |req_valid;
    err        = (|addr_q[31:AddrWidth])
               || (f3_q == 3'b010 && addr_q[AddrWidth-1:0] > {{(AddrWidth-2){1'b1}}, 2'b00})
               || (we_q ? f3_q >= 3'b011 : (f3_q == 3'b011 || f3_q[2:1] == 2'b11))
               || (f3_q[1:0] == 2'b01 && addr_q[0])
               || (f3_q == 3'b010 && addr_q[1:0] != 2'b00);
    req_ready  = accept ? 2'b01 << grant : 2'b00;
    resp_valid = (rst_n && state_q == S_RESP) ? 2'b01 << id_q : 2'b00;
    mem_we     = rst_n && state_q == S_ACCESS && we_q && !err;
    mem_addr   = addr_q[AddrWidth-1:0];
    mem_wdata  = wdata_q;
    mem_funct3 = f3_q;
    resp_data  = rdata_q;
    resp_err   = err_q;
  end
  // Next-state: latch the winner in IDLE, capture the memory result in ACCESS, hand priority over after RESP
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = S_ACCESS;
      id_d    = grant;
      we_d    = req_we[grant];
      f3_d    = grant ? req_funct3[5:3] : req_funct3[2:0];
      addr_d  = grant ? req_addr[63:32] : req_addr[31:0];
      wdata_d = grant ? req_wdata[63:32] : req_wdata[31:0];
    end else if (state_q == S_ACCESS) begin
      state_d = S_RESP;
      rdata_d = (err || we_q) ? 32'd0 : mem_rdata;
      err_d   = err;
    end else if (state_q == S_RESP && resp_ready[id_q]) begin
      state_d = S_IDLE;
      prio_d  = ~id_q;
    end
  end
  // State registers; reset discards any in-flight transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] pg0_q, pg0_d, pg1_q, pg1_d, perr_q, perr_d;
  // Saturating event counters: accepts per port and errored accesses
  always_comb begin
    pg0_d       = (accept && !grant && !(&pg0_q)) ? pg0_q + 32'd1 : pg0_q;
    pg1_d       = (accept && grant && !(&pg1_q)) ? pg1_q + 32'd1 : pg1_q;
    perr_d      = (rst_n && state_q == S_ACCESS && err && !(&perr_q)) ? perr_q + 32'd1 : perr_q;
    perf_grant0 = pg0_q;
    perf_grant1 = pg1_q;
    perf_err    = perr_q;
  end
  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pg0_q  <= 32'd0;
      pg1_q  <= 32'd0;
      perr_q <= 32'd0;
    end else begin
      pg0_q  <= pg0_d;
      pg1_q  <= pg1_d;
      perr_q <= perr_d;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter_rv32.sv
// tb_dmem_arbiter_rv32: directed bench with a transaction-level reference model checked every cycle
module tb_dmem_arbiter_rv32;
  localparam int AW = 14;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0, req_ready, req_we = '0, resp_valid, resp_ready = '0;
  logic [5:0]    req_funct3 = '0;
  logic [63:0]   req_addr = '0, req_wdata = '0;
  logic [31:0]   resp_data, mem_wdata, mem_rdata;
  logic          resp_err, mem_we;
  logic [AW-1:0] mem_addr;
  logic [2:0]    mem_funct3;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_err;
`endif
  int total = 0, bad = 0;

  dmem_arbiter_rv32 #(.AddrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_err(perf_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Byte-addressed memory attached to the DUT: combinational read, write on clock
  bit [7:0] mem [0:(1<<AW)-1];
  int we_cnt = 0;
  always_comb begin
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      3'b100:  mem_rdata = {24'd0, mem[mem_addr]};
      3'b001:  mem_rdata = {{16{mem[mem_addr+1][7]}}, mem[mem_addr+1], mem[mem_addr]};
      3'b101:  mem_rdata = {16'd0, mem[mem_addr+1], mem[mem_addr]};
      default: mem_rdata = {mem[mem_addr+3], mem[mem_addr+2], mem[mem_addr+1], mem[mem_addr]};
    endcase
  end
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      mem[mem_addr] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[mem_addr+1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[mem_addr+2] <= mem_wdata[23:16];
        mem[mem_addr+3] <= mem_wdata[31:24];
      end
    end
  end

  // Reference model: legality rules, shadow memory and expected load results
  bit [7:0] ref_mem [0:(1<<AW)-1];
  function automatic bit f_err(input bit we, input bit [2:0] f3, input bit [31:0] a);
    bit bad_f3 = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    return (a >= 32'(1 << AW)) || (f3 == 3'd2 && a > 32'((1 << AW) - 4)) || bad_f3 ||
           ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
  endfunction
  function automatic bit [31:0] f_load(input bit [2:0] f3, input bit [31:0] a);
    int i = int'(a[AW-1:0]);
    bit [31:0] w = {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    if (f3 == 3'd0) return 32'($signed(w[7:0]));
    if (f3 == 3'd4) return {24'd0, w[7:0]};
    if (f3 == 3'd1) return 32'($signed(w[15:0]));
    if (f3 == 3'd5) return {16'd0, w[15:0]};
    return w;
  endfunction

  bit busy = 0, in_access = 0, last = 1, m_id, m_store, g;
  bit [2:0]  m_f3;
  bit [31:0] m_addr, m_wdata, m_data, m_err;
  // Cycle compare against the model: idle grant, single-cycle access, held response
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      busy = 0; in_access = 0; last = 1;
    end else if (!busy) begin
      g = (req_valid == 2'b11) ? ~last : req_valid[1];
      chk("idle_req_ready", req_ready, req_valid == 0 ? 0 : 1 << g);
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_mem_we", mem_we, 0);
      if (req_valid != 0) begin
        busy = 1; in_access = 1; m_id = g;
        m_f3 = req_funct3[3*g +: 3]; m_addr = req_addr[32*g +: 32]; m_wdata = req_wdata[32*g +: 32];
        m_err = 32'(f_err(req_we[g], m_f3, m_addr));
        m_store = req_we[g] && m_err == 0;
        m_data = (req_we[g] || m_err != 0) ? 0 : f_load(m_f3, m_addr);
      end
    end else if (in_access) begin
      chk("acc_req_ready", req_ready, 0);
      chk("acc_resp_valid", resp_valid, 0);
      chk("acc_mem_we", mem_we, 32'(m_store));
      chk("acc_mem_addr", 32'(mem_addr), 32'(m_addr[AW-1:0]));
      chk("acc_mem_funct3", 32'(mem_funct3), 32'(m_f3));
      if (m_store) begin
        chk("acc_mem_wdata", mem_wdata, m_wdata);
        for (int b = 0; b < (m_f3 == 3'd2 ? 4 : m_f3 == 3'd1 ? 2 : 1); b++)
          ref_mem[int'(m_addr[AW-1:0]) + b] = m_wdata[8*b +: 8];
      end
      in_access = 0;
    end else begin
      chk("rsp_req_ready", req_ready, 0);
      chk("rsp_resp_valid", resp_valid, 1 << m_id);
      chk("rsp_mem_we", mem_we, 0);
      chk("rsp_resp_data", resp_data, m_data);
      chk("rsp_resp_err", resp_err, m_err);
      if (resp_ready[m_id]) begin busy = 0; last = m_id; end
    end
  end

  task automatic wait_rdy(input int p, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[p] && n < 30);
    chk(nm, req_ready[p], 1);
  endtask

  task automatic set_req(input int p, input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    req_we[p] = we; req_funct3[3*p +: 3] = f3; req_addr[32*p +: 32] = a; req_wdata[32*p +: 32] = wd;
    req_valid[p] = 1;
  endtask

  task automatic txn(input int p, input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                     output bit [31:0] d, output bit e, output int lat);
    set_req(p, we, f3, a, wd);
    resp_ready[p] = 1;
    wait_rdy(p, "txn_accept");
    @(posedge clk); #1 req_valid[p] = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid[p] && lat < 20);
    d = resp_data; e = resp_err;
    @(posedge clk); #1 resp_ready[p] = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  bit [31:0] d, d0;
  bit e;
  int lat, k, n, c0;
  bit gr [4];

  initial begin
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp_data", resp_data, 0);
    chk("reset_resp_err", resp_err, 0);
    chk("reset_mem_we", mem_we, 0);
    req_valid = 0;
    @(posedge clk); #1 rst_n = 1;

    txn(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, d, e, lat);
    chk("sw_err", e, 0); chk("sw_data", d, 0); chk("sw_latency", lat, 2);
    txn(0, 0, 3'd2, 32'h10, 0, d, e, lat);
    chk("lw_data", d, 32'hDEADBEEF); chk("lw_err", e, 0); chk("lw_latency", lat, 2);

    txn(1, 1, 3'd0, 32'h21, 32'h80, d, e, lat);
    chk("sb_err", e, 0);
    txn(0, 0, 3'd0, 32'h21, 0, d, e, lat);
    chk("lb_data", d, 32'hFFFFFF80);
    txn(0, 0, 3'd4, 32'h21, 0, d, e, lat);
    chk("lbu_data", d, 32'h00000080);

    do_reset();
    set_req(0, 0, 3'd2, 32'h10, 0);
    set_req(1, 0, 3'd4, 32'h21, 0);
    resp_ready = 2'b11;
    k = 0; n = 0;
    while (k < 4 && n < 60) begin
      @(negedge clk); n++;
      if (req_ready != 0) begin gr[k] = req_ready[1]; k++; end
    end
    chk("rr_count", k, 4);
    chk("rr_grant0", gr[0], 0); chk("rr_grant1", gr[1], 1);
    chk("rr_grant2", gr[2], 0); chk("rr_grant3", gr[3], 1);
    @(posedge clk); #1 req_valid = 0;
    repeat (6) @(posedge clk);
    #1 resp_ready = 0;

    c0 = we_cnt;
    txn(0, 1, 3'd2, 32'h12, 32'h11111111, d, e, lat);
    chk("sw_mis_err", e, 1); chk("sw_mis_data", d, 0); chk("sw_mis_no_write", we_cnt - c0, 0);
    txn(0, 0, 3'd2, 32'h10, 0, d, e, lat);
    chk("lw_after_err", d, 32'hDEADBEEF);
    txn(0, 0, 3'd6, 32'h10, 0, d, e, lat);
    chk("lw_bad_f3_err", e, 1);
    txn(1, 0, 3'd2, 32'h4000, 0, d, e, lat);
    chk("lw_range_err", e, 1);
    txn(1, 0, 3'd5, 32'h23, 0, d, e, lat);
    chk("lhu_mis_err", e, 1);
`ifdef DMEM_ARB_PERF_EN
    chk("perf_err", perf_err, 4);
`endif

    set_req(0, 0, 3'd2, 32'h10, 0);
    wait_rdy(0, "hold_accept");
    @(posedge clk); #1 req_valid[0] = 0;
    set_req(1, 0, 3'd4, 32'h21, 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 2'b01);
      chk("hold_resp_data", resp_data, 32'hDEADBEEF);
      chk("hold_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 2'b11;
    wait_rdy(1, "hold_p1_accept");
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[1] && n < 20);
    chk("hold_p1_data", resp_data, 32'h80);
    @(posedge clk); #1 resp_ready = 0;

    c0 = we_cnt;
    set_req(1, 1, 3'd2, 32'h40, 32'h12345678);
    wait_rdy(1, "rst_sw_accept");
    @(posedge clk); #1 req_valid = 0; rst_n = 0;
    @(negedge clk);
    chk("rst_acc_mem_we", mem_we, 0);
    @(posedge clk); #1 rst_n = 1;
    chk("rst_acc_no_write", we_cnt - c0, 0);
    chk("rst_acc_resp_valid", resp_valid, 0);
    set_req(0, 0, 3'd2, 32'h40, 0);
    set_req(1, 0, 3'd2, 32'h10, 0);
    resp_ready = 2'b11;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 2'b01);
    @(posedge clk); #1 req_valid[0] = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 20);
    chk("post_rst_lw_data", resp_data, 0);
    wait_rdy(1, "post_rst_p1_accept");
    @(posedge clk); #1 req_valid = 0;
    repeat (4) @(posedge clk);
    #1 resp_ready = 0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
